mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
//  Memory-access pipeline stage; consumes exec outputs, drives data memory via req/ack, produces MEM/WB writeback.
//  EX/MEM register captures exec results; stores get byte enables, loads are aligned and extended (big-endian).
//  Writeback data = link address (Jal) | extended load (MemToReg) | ALUout. Stalls upstream while access waits.
// PARAMETERS
//  TIMEOUT  16  wait cycles before an unacknowledged access aborts (used only with MEM_TIMEOUT_EN)
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  MemWr        in   1   store (from exec)
//  MemToReg     in   1   load; writeback from memory
//  RegWr        in   1   register write enable
//  Dsize        in   2   00 word, 01 half, 10 byte, 11 treated as word
//  Loadext      in   1   1 sign-extend load, 0 zero-extend
//  Jal          in   1   writeback Delayslot2 (link address)
//  FPoint       in   2   FP register-file select, passed through
//  ALUout       in   32  effective address / ALU result
//  BusB         in   32  store data
//  Delayslot2   in   32  link address
//  Rw           in   5   destination register
//  dmem_req     out  1   access request
//  dmem_we      out  1   1 store, 0 load
//  dmem_addr    out  32  word-aligned address {ALUout[31:2],2'b00}
//  dmem_be      out  4   byte enables, be[3] = bits[31:24]
//  dmem_wdata   out  32  lane-replicated store data
//  dmem_rdata   in   32  load data, valid with ack
//  dmem_ack     in   1   access complete (same cycle as req allowed)
//  mem_stall    out  1   hold upstream stages
//  misalign     out  1   one-cycle pulse: misaligned access dropped
//  bus_err      out  1   one-cycle pulse: access timed out
//  wb_RegWr     out  1   to writeback
//  wb_Rw        out  5
//  wb_FPoint    out  2
//  wb_Data      out  32
// BEHAVIOUR
//  Reset: EX/MEM and MEM/WB registers all zero; FSM IDLE; counter 0; every output 0.
//  EX/MEM loads exec inputs on each edge with mem_stall=0; holds with mem_stall=1.
//  memop = MemWr|MemToReg. Misaligned: half with addr[0]=1, word with addr[1:0]!=0 -> no req, misalign pulse, bubble.
//  dmem_req = memop & aligned & (IDLE|WAIT); all dmem_* combinational from EX/MEM, stable while stalled.
//  mem_stall = dmem_req & ~dmem_ack. Zero-wait ack -> 1-cycle stage latency, no stall.
//  FSM IDLE: req & ~ack -> WAIT (counter cleared); otherwise stay. WAIT: ack -> IDLE; else counter++.
//  Byte lanes: offset 0 -> [31:24] ... 3 -> [7:0]; half offset 0 -> [31:16], 2 -> [15:0].
//  wdata: byte {4{BusB[7:0]}}, half {2{BusB[15:0]}}, word BusB. be set only for addressed lanes.
//  Load: select lane from rdata, extend per Loadext to 32 bits.
//  MEM/WB loads every edge: bubble (all zero) when mem_stall or dropped access, else result.
//  wb_Data priority Jal > MemToReg > ALUout. Stores write wb_RegWr=RegWr (normally 0).
//  Ack with no req ignored. Reset mid-wait: req drops immediately (async), no writeback.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined: WAIT counter reaching TIMEOUT aborts -> IDLE, mem_stall low, bus_err pulse,
//   MEM/WB bubble; EX/MEM takes next instruction. Late ack after abort ignored.
//  Not defined: no counter; WAIT holds indefinitely until ack; bus_err tied 0.
// STRUCTURE
//  Package mem_pkg: Dsize encodings, FSM state localparams (IDLE, WAIT), lane-select helpers.
//  Sub-module load_align: (rdata, offset[1:0], Dsize, Loadext) -> 32-bit extended result; combinational.
//  Top: EX/MEM register, FSM + counter, store lane logic, writeback mux, MEM/WB register.
// TESTING
//  ALU op RegWr=1 Rw=5 ALUout=0x1234 -> next cycle wb_RegWr=1 wb_Rw=5 wb_Data=0x1234; dmem_req never high.
//  lb addr 0x103 Loadext=1 rdata=0x000000F0, ack same cycle -> wb_Data=0xFFFFFFF0; Loadext=0 -> 0x000000F0.
//  sh addr 0x102 BusB=0x0000ABCD -> dmem_addr=0x100 be=0011 wdata=0xABCDABCD we=1; no stall on immediate ack.
//  lw ack after 3 cycles -> mem_stall high 3 cycles, addr stable, wb bubbles, then wb_Data=rdata.
//  lw addr 0x101 -> no req, misalign pulse 1 cycle, wb_RegWr=0; Jal Rw=31 -> wb_Data=Delayslot2.
//  TIMEOUT=4, no ack: with MEM_TIMEOUT_EN bus_err after 4 WAIT cycles; without stall persists; rst_n low mid-wait -> req 0 at once.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the memory-access stage.
// The optional access timeout is enabled by defining MEM_TIMEOUT_EN.
package mem_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic {IDLE, WAIT} state_t;

    typedef struct packed {
        logic        MemWr;
        logic        MemToReg;
        logic        RegWr;
        logic [1:0]  Dsize;
        logic        Loadext;
        logic        Jal;
        logic [1:0]  FPoint;
        logic [31:0] ALUout;
        logic [31:0] BusB;
        logic [31:0] Delayslot2;
        logic [4:0]  Rw;
    } ex_mem_t;

    function automatic logic isAligned(logic [1:0] size, logic [1:0] off);
        unique case (size)
            SZ_BYTE: isAligned = 1'b1;
            SZ_HALF: isAligned = ~off[0];
            default: isAligned = (off == 2'b00);
        endcase
    endfunction

    // Big-endian lanes: offset 0 is bits [31:24]
    function automatic logic [3:0] laneBe(logic [1:0] size, logic [1:0] off);
        unique case (size)
            SZ_BYTE: laneBe = 4'b1000 >> off;
            SZ_HALF: laneBe = off[1] ? 4'b0011 : 4'b1100;
            default: laneBe = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] laneData(logic [1:0] size, logic [31:0] d);
        unique case (size)
            SZ_BYTE: laneData = {4{d[7:0]}};
            SZ_HALF: laneData = {2{d[15:0]}};
            default: laneData = d;
        endcase
    endfunction

    function automatic logic [7:0] laneByte(logic [31:0] d, logic [1:0] off);
        unique case (off)
            2'd0:    laneByte = d[31:24];
            2'd1:    laneByte = d[23:16];
            2'd2:    laneByte = d[15:8];
            default: laneByte = d[7:0];
        endcase
    endfunction

endpackage

// File: rtl/mem_if.sv
// Data-memory request/acknowledge bus.
// The master drives the access, the slave returns data with ack.
interface mem_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (
        output req, we, addr, be, wdata,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output rdata, ack
    );
endinterface

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a big-endian load word
// and sign- or zero-extends it to 32 bits.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  Dsize,
    input  logic        Loadext,
    output logic [31:0] result
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = laneByte(rdata, offset);
        h = offset[1] ? rdata[15:0] : rdata[31:16];
        unique case (Dsize)
            SZ_BYTE: result = {{24{Loadext & b[7]}}, b};
            SZ_HALF: result = {{16{Loadext & h[15]}}, h};
            default: result = rdata;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: EX/MEM register, data-memory FSM, MEM/WB register.
// Define MEM_TIMEOUT_EN to abort accesses left unacknowledged for TIMEOUT wait cycles.
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemWr,
    input  logic        MemToReg,
    input  logic        RegWr,
    input  logic [1:0]  Dsize,
    input  logic        Loadext,
    input  logic        Jal,
    input  logic [1:0]  FPoint,
    input  logic [31:0] ALUout,
    input  logic [31:0] BusB,
    input  logic [31:0] Delayslot2,
    input  logic [4:0]  Rw,
    mem_if.master       dmem,
    output logic        mem_stall,
    output logic        misalign,
    output logic        bus_err,
    output logic        wb_RegWr,
    output logic [4:0]  wb_Rw,
    output logic [1:0]  wb_FPoint,
    output logic [31:0] wb_Data
);
    ex_mem_t     exm;
    state_t      state, stateNext;
    logic        memop, aligned, req, abort, drop;
    logic [31:0] loadData, result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) exm <= '0;
        else if (!mem_stall)
            exm <= '{MemWr, MemToReg, RegWr, Dsize, Loadext, Jal,
                     FPoint, ALUout, BusB, Delayslot2, Rw};
    end

    assign memop   = exm.MemWr | exm.MemToReg;
    assign aligned = isAligned(exm.Dsize, exm.ALUout[1:0]);
    assign req     = memop & aligned & (state == IDLE || state == WAIT);

    assign dmem.req   = req;
    assign dmem.we    = req & exm.MemWr;
    assign dmem.addr  = {exm.ALUout[31:2], 2'b00};
    assign dmem.be    = req ? laneBe(exm.Dsize, exm.ALUout[1:0]) : 4'b0000;
    assign dmem.wdata = laneData(exm.Dsize, exm.BusB);

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt, cntNext;

    // Abort once TIMEOUT full wait cycles have elapsed without ack
    assign abort = (state == WAIT) & ~dmem.ack & (cnt == CW'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= cntNext;
    end
`else
    assign abort = 1'b0 && (TIMEOUT > 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
`ifdef MEM_TIMEOUT_EN
        cntNext = cnt;
`endif
        unique case (state)
            IDLE: if (req & ~dmem.ack) begin
                stateNext = WAIT;
`ifdef MEM_TIMEOUT_EN
                cntNext = '0;
`endif
            end
            WAIT: begin
                if (dmem.ack | abort) stateNext = IDLE;
`ifdef MEM_TIMEOUT_EN
                else cntNext = cnt + 1'b1;
`endif
            end
            default: stateNext = IDLE;
        endcase
    end

    assign mem_stall = req & ~dmem.ack & ~abort;
    assign misalign  = memop & ~aligned;
    assign bus_err   = abort;
    assign drop      = misalign | abort;

    load_align u_align (
        .rdata  (dmem.rdata),
        .offset (exm.ALUout[1:0]),
        .Dsize  (exm.Dsize),
        .Loadext(exm.Loadext),
        .result (loadData)
    );

    assign result = exm.Jal      ? exm.Delayslot2 :
                    exm.MemToReg ? loadData       : exm.ALUout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || mem_stall || drop) begin
            wb_RegWr  <= 1'b0;
            wb_Rw     <= '0;
            wb_FPoint <= '0;
            wb_Data   <= '0;
        end else begin
            wb_RegWr  <= exm.RegWr;
            wb_Rw     <= exm.Rw;
            wb_FPoint <= exm.FPoint;
            wb_Data   <= result;
        end
    end
endmodule
